// File: rtl/wb_cpu_master.sv
// wb_cpu_master: bridge from the CPU load/store unit to a pipelined Wishbone bus.
// Accepts one request at a time and decodes the address into a one-hot slave select.
// Steers byte lanes and runs a single Wishbone cycle, which may stall or time out.
// It then returns a one-cycle response pulse carrying the extended load data or an error.
// Ports:
//   i_clk, i_rst_n             clock, synchronous active-low reset
//   i_req_*, o_req_ready       request handshake (addr, we, wdata, size, unsigned)
//   o_rsp_valid/rdata/err      one-cycle response
//   o_wb_*, i_wb_*             Wishbone master side (addr, data, sel, cyc, stb, we / data, ack, stall)
//   o_mux_slave_sel            registered one-hot slave select towards wb_mux
module wb_cpu_master #(
    parameter int BYTES          = 32,
    parameter int SLAVE_NUMBER   = 3,
    parameter logic [SLAVE_NUMBER*BYTES-1:0] SLAVE_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [SLAVE_NUMBER*BYTES-1:0] SLAVE_MASK = {3{32'hF000_0000}},
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [BYTES-1:0]        i_req_addr,
    input  logic                    i_req_we,
    input  logic [BYTES-1:0]        i_req_wdata,
    input  logic [1:0]              i_req_size,
    input  logic                    i_req_unsigned,
    output logic                    o_rsp_valid,
    output logic [BYTES-1:0]        o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic [BYTES-1:0]        o_wb_addr,
    output logic [BYTES-1:0]        o_wb_data,
    output logic [BYTES/8-1:0]      o_wb_sel,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_we,
    input  logic [BYTES-1:0]        i_wb_data,
    input  logic                    i_wb_ack,
    input  logic                    i_wb_stall,
    output logic [SLAVE_NUMBER-1:0] o_mux_slave_sel
);
    localparam int SEL_W = BYTES / 8;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value during the last bus cycle allowed before giving up.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    // Lowest-index matching slave wins: scan downwards so lower indices overwrite.
    function automatic logic [SLAVE_NUMBER-1:0] f_decode(input logic [BYTES-1:0] addr);
        logic [SLAVE_NUMBER-1:0] hit;
        hit = '0;
        for (int s = SLAVE_NUMBER - 1; s >= 0; s--) begin
            if ((addr & SLAVE_MASK[s*BYTES +: BYTES]) == SLAVE_BASE[s*BYTES +: BYTES]) begin
                hit    = '0;
                hit[s] = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    // Align the addressed lane to bit 0, truncate to the access size, then extend.
    function automatic logic [BYTES-1:0] f_load(input logic [BYTES-1:0] data, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
        logic [BYTES-1:0] sh;
        logic [BYTES-1:0] res;
        sh = data >> {lane, 3'b000};
        case (size)
            2'd0:    res = {{(BYTES-8){sh[7] & ~uns}}, sh[7:0]};
            2'd1:    res = {{(BYTES-16){sh[15] & ~uns}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    state_t                  r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [1:0]              r_size, w_size_nxt;
    logic [1:0]              r_lane, w_lane_nxt;
    logic                    r_uns, w_uns_nxt;
    logic                    r_req_ready, w_req_ready_nxt;
    logic                    r_rsp_valid, w_rsp_valid_nxt;
    logic [BYTES-1:0]        r_rsp_rdata, w_rsp_rdata_nxt;
    logic                    r_rsp_err, w_rsp_err_nxt;
    logic [BYTES-1:0]        r_wb_addr, w_wb_addr_nxt;
    logic [BYTES-1:0]        r_wb_data, w_wb_data_nxt;
    logic [SEL_W-1:0]        r_wb_sel, w_wb_sel_nxt;
    logic                    r_wb_cyc, w_wb_cyc_nxt;
    logic                    r_wb_stb, w_wb_stb_nxt;
    logic                    r_wb_we, w_wb_we_nxt;
    logic [SLAVE_NUMBER-1:0] r_slave_sel, w_slave_sel_nxt;
    logic                    w_on_bus;

    logic [SLAVE_NUMBER-1:0] w_dec;
    logic                    w_misalign;
    logic                    w_illegal;
    logic [SEL_W-1:0]        w_sel_req;
    logic [BYTES-1:0]        w_wdata_rep;
    logic [BYTES-1:0]        w_load;
    logic                    w_timeout;

    assign w_dec      = f_decode(i_req_addr);
    assign w_misalign = ((i_req_size == 2'd1) && i_req_addr[0]) ||
                        ((i_req_size == 2'd2) && (i_req_addr[1:0] != 2'b00));
    assign w_illegal  = (i_req_size == 2'd3) || w_misalign || (w_dec == '0);
    assign w_load     = f_load(i_wb_data, r_lane, r_size, r_uns);
    assign w_timeout  = (r_cnt == CNT_LAST);

    // Byte enables and lane-replicated write data for the incoming request.
    always_comb begin
        w_sel_req   = '0;
        w_wdata_rep = i_req_wdata;
        case (i_req_size)
            2'd0: begin
                w_sel_req   = SEL_W'(4'b0001 << i_req_addr[1:0]);
                w_wdata_rep = {4{i_req_wdata[7:0]}};
            end
            2'd1: begin
                w_sel_req   = SEL_W'(4'b0011 << i_req_addr[1:0]);
                w_wdata_rep = {2{i_req_wdata[15:0]}};
            end
            2'd2: begin
                w_sel_req   = SEL_W'(4'hF);
                w_wdata_rep = i_req_wdata;
            end
            default: begin
                w_sel_req   = '0;
                w_wdata_rep = i_req_wdata;
            end
        endcase
    end

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_size_nxt      = r_size;
        w_lane_nxt      = r_lane;
        w_uns_nxt       = r_uns;
        w_rsp_rdata_nxt = '0;
        w_rsp_err_nxt   = 1'b0;
        w_wb_addr_nxt   = r_wb_addr;
        w_wb_data_nxt   = r_wb_data;
        w_wb_sel_nxt    = r_wb_sel;
        w_wb_we_nxt     = r_wb_we;
        w_slave_sel_nxt = r_slave_sel;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid && r_req_ready) begin
                    w_size_nxt = i_req_size;
                    w_lane_nxt = i_req_addr[1:0];
                    w_uns_nxt  = i_req_unsigned;
                    w_cnt_nxt  = '0;
                    if (w_illegal) begin
                        w_state_nxt   = S_RESP;
                        w_rsp_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = S_REQ;
                        w_wb_addr_nxt   = {i_req_addr[BYTES-1:2], 2'b00};
                        w_wb_data_nxt   = w_wdata_rep;
                        w_wb_sel_nxt    = w_sel_req;
                        w_wb_we_nxt     = i_req_we;
                        w_slave_sel_nxt = w_dec;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // An ack only counts once the strobe has been taken (no stall).
                if (i_wb_ack && !i_wb_stall) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_rdata_nxt = r_wb_we ? '0 : w_load;
                end else if (w_timeout) begin
                    w_state_nxt   = S_RESP;
                    w_rsp_err_nxt = 1'b1;
                end else if (!i_wb_stall) begin
                    w_state_nxt = S_WAIT_ACK;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_WAIT_ACK: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (i_wb_ack) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_rdata_nxt = r_wb_we ? '0 : w_load;
                end else if (w_timeout) begin
                    w_state_nxt   = S_RESP;
                    w_rsp_err_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Bus-side signals exist only while a cycle is in flight.
        w_on_bus = (w_state_nxt == S_REQ) || (w_state_nxt == S_WAIT_ACK);
        if (!w_on_bus) begin
            w_wb_addr_nxt   = '0;
            w_wb_data_nxt   = '0;
            w_wb_sel_nxt    = '0;
            w_wb_we_nxt     = 1'b0;
            w_slave_sel_nxt = '0;
        end else begin
            w_wb_addr_nxt   = w_wb_addr_nxt;
        end
        w_wb_cyc_nxt    = w_on_bus;
        w_wb_stb_nxt    = (w_state_nxt == S_REQ);
        w_req_ready_nxt = (w_state_nxt == S_IDLE);
        w_rsp_valid_nxt = (w_state_nxt == S_RESP);
    end

    // State, context and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_size      <= 2'd0;
            r_lane      <= 2'd0;
            r_uns       <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_wb_sel    <= '0;
            r_wb_cyc    <= 1'b0;
            r_wb_stb    <= 1'b0;
            r_wb_we     <= 1'b0;
            r_slave_sel <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_size      <= w_size_nxt;
            r_lane      <= w_lane_nxt;
            r_uns       <= w_uns_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_wb_addr   <= w_wb_addr_nxt;
            r_wb_data   <= w_wb_data_nxt;
            r_wb_sel    <= w_wb_sel_nxt;
            r_wb_cyc    <= w_wb_cyc_nxt;
            r_wb_stb    <= w_wb_stb_nxt;
            r_wb_we     <= w_wb_we_nxt;
            r_slave_sel <= w_slave_sel_nxt;
        end
    end

    assign o_req_ready     = r_req_ready;
    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_rdata     = r_rsp_rdata;
    assign o_rsp_err       = r_rsp_err;
    assign o_wb_addr       = r_wb_addr;
    assign o_wb_data       = r_wb_data;
    assign o_wb_sel        = r_wb_sel;
    assign o_wb_cyc        = r_wb_cyc;
    assign o_wb_stb        = r_wb_stb;
    assign o_wb_we         = r_wb_we;
    assign o_mux_slave_sel = r_slave_sel;

endmodule

// File: tb/tb_wb_cpu_master.sv
// Self-checking bench for wb_cpu_master: directed requests against a per-cycle
// expectation derived from transaction-level rules, plus literal pins.
module tb_wb_cpu_master;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] wb_addr;
    logic [31:0] wb_dout;
    logic [3:0]  wb_sel;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_din;
    logic        wb_ack;
    logic        wb_stall;
    logic [2:0]  slave_sel;

    always #5 clk = ~clk;

    wb_cpu_master #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_addr(req_addr), .i_req_we(req_we), .i_req_wdata(req_wdata),
        .i_req_size(req_size), .i_req_unsigned(req_unsigned),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_wb_addr(wb_addr), .o_wb_data(wb_dout), .o_wb_sel(wb_sel),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .i_wb_data(wb_din), .i_wb_ack(wb_ack), .i_wb_stall(wb_stall),
        .o_mux_slave_sel(slave_sel)
    );

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d, t=%0t): got 0x%08h expected 0x%08h", name, k, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    function automatic logic [2:0] m_slave(input logic [31:0] a);
        logic [31:0] base [3];
        base = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000};
        for (int s = 0; s < 3; s++)
            if ((a & 32'hF000_0000) == base[s]) return 3'(1 << s);
        return 3'b000;
    endfunction

    function automatic bit m_legal(input logic [31:0] a, input int size);
        if (size == 3) return 1'b0;
        if (size == 1 && (a % 2) != 0) return 1'b0;
        if (size == 2 && (a % 4) != 0) return 1'b0;
        return m_slave(a) != 3'b000;
    endfunction

    function automatic logic [3:0] m_sel(input int lane, input int size);
        int p;
        p = 1;
        for (int i = 0; i < lane; i++) p = p * 2;
        if (size == 0) return 4'(p);
        if (size == 1) return 4'(3 * p);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] w, input int size);
        if (size == 0) return (w % 32'd256) * 32'h0101_0101;
        if (size == 1) return (w % 32'd65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] d, input int lane, input int size, input bit uns);
        longint unsigned du;
        longint unsigned p;
        longint v;
        du = 64'(d);
        p  = 64'd1;
        for (int i = 0; i < lane; i++) p = p * 64'd256;
        if (size == 0) begin
            v = longint'((du / p) % 64'd256);
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 1) begin
            v = longint'((du / p) % 64'd65536);
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(du);
        end
        return v[31:0];
    endfunction

    // current transaction descriptor
    logic [31:0] t_addr, t_wdata, t_rd;
    bit          t_we, t_uns, t_tmo, t_legal, active;
    int          t_size, t_S, t_E, t_R;
    int          rsp_seen, last_k;
    logic [31:0] last_rdata, last_wb_data;
    logic        last_err;
    logic [3:0]  last_wb_sel;

    // Compare process: every cycle of a transaction, outputs vs. the model.
    always @(negedge clk) begin
        if (active) begin
            bit e_bus, e_stb, e_rsp;
            e_bus = t_legal && k >= 1 && k <= t_E;
            e_stb = e_bus && k <= t_S + 1;
            e_rsp = (k == t_R);
            chk("cyc", 32'(wb_cyc), 32'(e_bus));
            chk("stb", 32'(wb_stb), 32'(e_stb));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            chk("req_ready", 32'(req_ready), 32'(k > t_R));
            chk("rsp_err", 32'(rsp_err), 32'(e_rsp && (!t_legal || t_tmo)));
            chk("rsp_rdata", rsp_rdata, (e_rsp && t_legal && !t_tmo && !t_we) ? m_rd(t_rd, int'(t_addr % 4), t_size, t_uns) : 32'h0);
            chk("wb_addr", wb_addr, e_bus ? (t_addr & 32'hFFFF_FFFC) : 32'h0);
            chk("wb_data", wb_dout, e_bus ? m_wdata(t_wdata, t_size) : 32'h0);
            chk("wb_sel", 32'(wb_sel), e_bus ? 32'(m_sel(int'(t_addr % 4), t_size)) : 32'h0);
            chk("wb_we", 32'(wb_we), 32'(e_bus && t_we));
            chk("slave_sel", 32'(slave_sel), e_bus ? 32'(m_slave(t_addr)) : 32'h0);
            if (rsp_valid) begin
                rsp_seen++;
                last_k     = k;
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
            end
            if (wb_cyc) begin
                last_wb_data = wb_dout;
                last_wb_sel  = wb_sel;
            end
        end
    end

    // Issue one request; S stall cycles, ack d cycles after the strobe is taken.
    task automatic run(input logic [31:0] addr, input bit we, input logic [31:0] wdata, input int size,
                       input bit uns, input int S, input int d, input logic [31:0] rd, input bit tmo);
        t_addr = addr; t_we = we; t_wdata = wdata; t_size = size; t_uns = uns;
        t_S = S; t_rd = rd; t_tmo = tmo;
        t_legal = m_legal(addr, size);
        t_E = tmo ? T : S + 1 + d;
        t_R = t_legal ? t_E + 1 : 1;
        rsp_seen = 0;
        req_addr = addr; req_we = we; req_wdata = wdata; req_size = 2'(size); req_unsigned = uns;
        req_valid = 1'b1; wb_ack = 1'b0; wb_stall = 1'b0;
        @(posedge clk); #1;
        // scramble request inputs: the DUT must have latched them
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h1357_9BDF; req_size = 2'd0;
        req_we = ~we; req_unsigned = ~uns;
        for (int kk = 1; kk <= t_R + 2; kk++) begin
            k = kk; active = 1'b1;
            wb_stall = t_legal && kk <= S;
            wb_ack   = (t_legal && !tmo && kk == t_E) || (tmo && (kk == t_R || kk == t_R + 1));
            wb_din   = wb_ack ? rd : 32'hA5A5_A5A5;
            @(posedge clk); #1;
        end
        active = 1'b0; wb_ack = 1'b0; wb_stall = 1'b0;
        chk("rsp_count", 32'(rsp_seen), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0; req_wdata = 32'h0;
        req_size = 2'd0; req_unsigned = 1'b0; wb_din = 32'h0; wb_ack = 1'b0; wb_stall = 1'b0;
        active = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_stb", 32'(wb_stb), 32'd0);
        chk("rst_sel", 32'(slave_sel), 32'd0);
        chk("rst_addr", wb_addr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // word read, ack one cycle after strobe
        run(32'h0000_0004, 1'b0, 32'h0, 2, 1'b0, 0, 1, 32'hDEAD_BEEF, 1'b0);
        chk("word_lat", 32'(last_k), 32'd3);
        chk("word_rdata", last_rdata, 32'hDEAD_BEEF);
        chk("word_sel", 32'(last_wb_sel), 32'hF);
        // byte loads, signed and unsigned
        run(32'h1000_0003, 1'b0, 32'h0, 0, 1'b0, 0, 1, 32'h80FF_0000, 1'b0);
        chk("byte_s", last_rdata, 32'hFFFF_FF80);
        chk("byte_sel", 32'(last_wb_sel), 32'h8);
        run(32'h1000_0003, 1'b0, 32'h0, 0, 1'b1, 0, 1, 32'h80FF_0000, 1'b0);
        chk("byte_u", last_rdata, 32'h0000_0080);
        // half store
        run(32'h2000_0002, 1'b1, 32'h0000_ABCD, 1, 1'b0, 0, 1, 32'h1111_2222, 1'b0);
        chk("half_st_data", last_wb_data, 32'hABCD_ABCD);
        chk("half_st_sel", 32'(last_wb_sel), 32'hC);
        chk("half_st_rdata", last_rdata, 32'h0);
        // illegal requests
        run(32'h0000_0002, 1'b0, 32'h0, 2, 1'b0, 0, 1, 32'h0, 1'b0);
        chk("misal_lat", 32'(last_k), 32'd1);
        chk("misal_err", 32'(last_err), 32'd1);
        run(32'h3000_0000, 1'b0, 32'h0, 2, 1'b0, 0, 1, 32'h0, 1'b0);
        chk("unmapped_err", 32'(last_err), 32'd1);
        run(32'h0000_0000, 1'b0, 32'h0, 3, 1'b0, 0, 1, 32'h0, 1'b0);
        chk("size3_err", 32'(last_err), 32'd1);
        // stall 4 cycles then ack
        run(32'h0000_0010, 1'b0, 32'h0, 2, 1'b0, 4, 1, 32'h0123_4567, 1'b0);
        chk("stall_lat", 32'(last_k), 32'd7);
        // combinational ack
        run(32'h1000_0008, 1'b0, 32'h0, 2, 1'b0, 0, 0, 32'hCAFE_F00D, 1'b0);
        chk("comb_lat", 32'(last_k), 32'd2);
        // timeout, late acks ignored
        run(32'h2000_0000, 1'b0, 32'h0, 2, 1'b0, 0, 0, 32'h5555_AAAA, 1'b1);
        chk("tmo_lat", 32'(last_k), 32'd9);
        chk("tmo_err", 32'(last_err), 32'd1);
        // extra lanes / sizes
        run(32'h0000_0002, 1'b0, 32'h0, 1, 1'b0, 1, 2, 32'h8001_1234, 1'b0);
        chk("half_s", last_rdata, 32'hFFFF_8001);
        run(32'h0000_0000, 1'b0, 32'h0, 1, 1'b1, 0, 3, 32'h8001_F234, 1'b0);
        chk("half_u", last_rdata, 32'h0000_F234);
        run(32'h1000_0001, 1'b1, 32'h0000_005A, 0, 1'b0, 0, 1, 32'h0, 1'b0);
        chk("byte_st_data", last_wb_data, 32'h5A5A_5A5A);
        chk("byte_st_sel", 32'(last_wb_sel), 32'h2);

        // reset asserted while waiting for ack
        req_addr = 32'h0000_0004; req_size = 2'd2; req_we = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wa_cyc", 32'(wb_cyc), 32'd1);
        chk("wa_stb", 32'(wb_stb), 32'd0);
        chk("wa_sel", 32'(slave_sel), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        wb_ack = 1'b1; wb_din = 32'h7777_7777;
        @(negedge clk);
        chk("mr_cyc", 32'(wb_cyc), 32'd0);
        chk("mr_stb", 32'(wb_stb), 32'd0);
        chk("mr_sel", 32'(slave_sel), 32'd0);
        chk("mr_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mr_ready", 32'(req_ready), 32'd1);
        chk("mr_rsp2", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1; wb_ack = 1'b0;
        @(negedge clk);
        chk("mr_rsp3", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        run(32'h2000_000C, 1'b0, 32'h0, 2, 1'b0, 0, 1, 32'h0BAD_F00D, 1'b0);
        chk("post_rst_rdata", last_rdata, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_cpu_master.md
# wb_cpu_master

Bridge between the CPU load/store unit and the Wishbone interconnect. It accepts one memory request at a time over a valid/ready handshake and decodes the address into a one-hot slave select for `wb_mux`. It also performs byte-lane steering and runs a single pipelined-Wishbone cycle (with stall and timeout). It returns sign- or zero-extended read data, or an error, as a one-cycle response pulse.

## Interface
- `BYTES`, 32: data/address width in bits; only 32 is supported.
- `SLAVE_NUMBER`, 3: number of slaves; width of `o_mux_slave_sel`.
- `SLAVE_BASE`, {32'h2000_0000, 32'h1000_0000, 32'h0000_0000}: packed `SLAVE_NUMBER*BYTES`; slice s is the base of slave s.
- `SLAVE_MASK`, {3{32'hF000_0000}}: packed `SLAVE_NUMBER*BYTES`; slave s matches when `(addr & mask_s) == base_s`.
- `TIMEOUT_CYCLES`, 255: maximum bus cycles without ack before the request is aborted with an error.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: reset, synchronous, active-low.
- `i_req_valid`, in, 1: request valid.
- `o_req_ready`, out, 1: request can be accepted.
- `i_req_addr`, in, BYTES: byte address.
- `i_req_we`, in, 1: 1 = store.
- `i_req_wdata`, in, BYTES: store data, right-aligned.
- `i_req_size`, in, 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `i_req_unsigned`, in, 1: zero-extend loads.
- `o_rsp_valid`, out, 1: one-cycle response pulse.
- `o_rsp_rdata`, out, BYTES: extended load data; 0 for stores and errors.
- `o_rsp_err`, out, 1: error flag, qualified by `o_rsp_valid`.
- `o_wb_addr`, out, BYTES: word-aligned address (bits [1:0] = 0).
- `o_wb_data`, out, BYTES: lane-replicated write data.
- `o_wb_sel`, out, BYTES/8: byte enables.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`, out, 1 each: Wishbone cycle, strobe and write-enable.
- `i_wb_data`, in, BYTES: read data from the mux.
- `i_wb_ack`, `i_wb_stall`, in, 1 each: Wishbone ack and stall from the mux.
- `o_mux_slave_sel`, out, SLAVE_NUMBER: one-hot slave select to the mux.

## Operation
- FSM states: IDLE, REQ, WAIT_ACK, RESP.
- IDLE:
  - `o_req_ready`=1.
  - On `i_req_valid`, latch the request and decode it.
  - If the request is illegal, go to RESP with err=1 and run no bus cycle. Illegal means any of: size=3; misaligned (half with addr[0]=1, word with addr[1:0]≠0); or no slave matches.
  - Otherwise go to REQ.
- Decode: the lowest-index matching slave wins; `o_mux_slave_sel` is the registered one-hot value.
- REQ:
  - `o_wb_cyc`=`o_wb_stb`=1.
  - If `i_wb_ack` is high in this cycle and `i_wb_stall`=0, go to RESP.
  - Else if `i_wb_stall`=0, go to WAIT_ACK.
  - Else stay in REQ.
- WAIT_ACK: `o_wb_cyc`=1, `o_wb_stb`=0; on `i_wb_ack`, go to RESP.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ or WAIT_ACK.
  - When it reaches `TIMEOUT_CYCLES` with no ack, go to RESP with err=1. `o_wb_cyc` and `o_wb_stb` drop the next cycle.
- RESP: `o_rsp_valid`=1 for exactly one cycle, then IDLE. `o_req_ready`=0 in this state.
- Lane steering (lane = addr[1:0]):
  - sel: byte = 4'b0001<<lane; half = 4'b0011<<lane; word = 4'hF.
  - Write data: byte replicated ×4; half replicated ×2; word unchanged.
  - Read data is captured on ack as `i_wb_data >> (8*lane)`, truncated to the access size, then sign-extended (`i_req_unsigned`=0) or zero-extended.
- Out-of-cycle signals: `o_mux_slave_sel`, `o_wb_addr`, `o_wb_data`, `o_wb_sel` and `o_wb_we` are held stable from REQ through the end of WAIT_ACK. They read 0 in IDLE and RESP.
- Late ack: an `i_wb_ack` arriving in IDLE or RESP (for example after a timeout) is ignored.

## Timing
- Reset: all outputs are 0, the state is IDLE, and the counter is 0. `o_req_ready` rises in the first cycle after `i_rst_n` goes high.
- Reset mid-cycle: asserting `i_rst_n`=0 in any state forces `o_wb_cyc` and `o_wb_stb` to 0 at the next edge, and no response is issued.
- Latency, counted from the accept edge (cycle 0):
  - REQ is in cycle 1.
  - With no stall and ack in cycle 2, `o_rsp_valid` is in cycle 3.
  - With ack in cycle 1 (combinational slave), `o_rsp_valid` is in cycle 2.
  - Decode/misalign errors: `o_rsp_valid` is in cycle 1.
- Each stall cycle adds one cycle; each ack wait adds one cycle.
- Timeout: err is reported at most `TIMEOUT_CYCLES`+2 cycles after accept.
- Throughput: one request every 3 cycles at best; there are no outstanding requests.

## Test plan
- Word read at 0x0000_0004 with slave0 acking next cycle and data 0xDEADBEEF → `o_mux_slave_sel`=3'b001, `o_wb_sel`=4'hF, `o_rsp_rdata`=0xDEADBEEF, err=0, 3-cycle latency.
- Byte loads at 0x1000_0003 with data 0x80FF_0000: signed → 0xFFFF_FF80; unsigned → 0x0000_0080; sel 4'b1000, slave 3'b010.
- Half store 0xABCD at 0x2000_0002 → `o_wb_data`=0xABCD_ABCD, sel 4'b1100, we=1, `o_rsp_rdata`=0.
- Illegal requests → `o_rsp_valid` in cycle 1 with err=1 and `o_wb_cyc` never high:
  - misaligned word at 0x0000_0002;
  - unmapped 0x3000_0000;
  - size=3.
- Stall held 4 cycles, then ack → stb stays high through the stall with stable addr; `o_rsp_valid` arrives 4 cycles later than the nominal case.
- Reset and timeout:
  - With no ack and `TIMEOUT_CYCLES`=8, err=1 and cyc drops; a later ack produces no second response.
  - Reset asserted in WAIT_ACK clears cyc and sel next cycle, with no `o_rsp_valid`.
